// File: rtl/imm_gen_pkg.sv
// Shared definitions for the RISC-V immediate generator: opcodes, format
// encoding and the queue entry layout.
package imm_gen_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int unsigned IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_ISH  = 3'd2,
        FMT_S    = 3'd3,
        FMT_SB   = 3'd4,
        FMT_U    = 3'd5,
        FMT_UJ   = 3'd6
    } imm_fmt_e;

    // Sized for the widest XLEN; narrower builds use the low bits only.
    // The tag lives beside the entry since its width is a per-instance parameter.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> extended immediate,
// format and illegal flag.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [31:0] raw;
    logic [2:0]  funct3;

    assign funct3 = instr[14:12];

    always_comb begin
        raw     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt = FMT_ISH;
                    if (XLEN == 64) raw = {26'b0, instr[25:20]};
                    else            raw = {27'b0, instr[24:20]};
                end else begin
                    fmt = FMT_I;
                    raw = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OP_LOAD, OP_JALR: begin
                fmt = FMT_I;
                raw = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt = FMT_S;
                raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt = FMT_SB;
                raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FMT_U;
                raw = {instr[31:12], 12'h000};
            end
            OP_JAL: begin
                fmt = FMT_UJ;
                raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Every format is already correct in 32 bits; widening is a plain sign extension.
    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode in front of a 2-entry output queue
// with registered in_ready, so no combinational path from out_ready to fetch.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;
    logic             dec_illegal;
    imm_entry_t       new_entry;
    imm_entry_t       slot [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       count;
    logic             push;
    logic             pop;
    imm_entry_t       head;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    always_comb begin
        new_entry         = '0;
        new_entry.imm     = IMM_MAX_W'(dec_imm);
        new_entry.fmt     = dec_fmt;
        new_entry.illegal = dec_illegal;
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Slot 0 is always the head; a pop shifts slot 1 down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            slot[0]  <= '0;
            slot[1]  <= '0;
            tag_q[0] <= '0;
            tag_q[1] <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    slot[count[0]]  <= new_entry;
                    tag_q[count[0]] <= in_tag;
                    count           <= count + 2'd1;
                end
                2'b01: begin
                    slot[0]  <= slot[1];
                    tag_q[0] <= tag_q[1];
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot[0]  <= new_entry;
                        tag_q[0] <= in_tag;
                    end else begin
                        slot[0]  <= slot[1];
                        tag_q[0] <= tag_q[1];
                        slot[1]  <= new_entry;
                        tag_q[1] <= in_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head        = out_valid ? slot[0] : '0;
    assign out_imm     = head.imm[XLEN-1:0];
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;
    assign out_tag     = out_valid ? tag_q[0] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share
// stimulus and are checked against a queue-based reference model.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_tag = '0;

    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm, out_tag;
    logic [2:0]  out_fmt;
    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [63:0] out_tag32;
    logic [2:0]  out_fmt32;

    imm_gen_pipe #(.XLEN(64), .TAG_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(64)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] tag;
    } exp_t;

    exp_t        mq[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic longint sext(input longint v, input int n);
        return (v >= (longint'(1) << (n - 1))) ? v - (longint'(1) << n) : v;
    endfunction

    // Field extraction by shifts and weights, straight from the ISA bit tables.
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] tag);
        exp_t   e;
        longint w, op, f3, v, v32;
        w  = longint'(i);
        op = w % 128;
        f3 = (w >> 12) % 8;
        v  = 0;
        e.fmt = FMT_NONE;
        e.ill = 1'b0;
        if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
            e.fmt = FMT_ISH;
            v     = (w >> 20) % 64;
        end else if (op == 'h13 || op == 'h03 || op == 'h67) begin
            e.fmt = FMT_I;
            v     = sext(w >> 20, 12);
        end else if (op == 'h23) begin
            e.fmt = FMT_S;
            v     = sext((w >> 25) * 32 + (w >> 7) % 32, 12);
        end else if (op == 'h63) begin
            e.fmt = FMT_SB;
            v     = sext((w >> 31) * 4096 + ((w >> 7) % 2) * 2048 + ((w >> 25) % 64) * 32
                         + ((w >> 8) % 16) * 2, 13);
        end else if (op == 'h37 || op == 'h17) begin
            e.fmt = FMT_U;
            v     = sext((w >> 12) * 4096, 32);
        end else if (op == 'h6f) begin
            e.fmt = FMT_UJ;
            v     = sext((w >> 31) * 1048576 + ((w >> 12) % 256) * 4096 + ((w >> 20) % 2) * 2048
                         + ((w >> 21) % 1024) * 2, 21);
        end else begin
            e.ill = 1'b1;
        end
        v32 = (e.fmt == FMT_ISH) ? (w >> 20) % 32 : v;
        e.imm64 = 64'(v);
        e.imm32 = 32'(v32);
        e.tag   = tag;
        return e;
    endfunction

    task automatic check_outputs();
        exp_t h;
        h = '{imm64: '0, imm32: '0, fmt: '0, ill: 1'b0, tag: '0};
        if (mq.size() != 0) h = mq[0];
        chk("in_ready",     in_ready,      mq.size() != 2);
        chk("in_ready32",   in_ready32,    mq.size() != 2);
        chk("out_valid",    out_valid,     mq.size() != 0);
        chk("out_valid32",  out_valid32,   mq.size() != 0);
        chk("out_imm",      out_imm,       h.imm64);
        chk("out_imm32",    out_imm32,     h.imm32);
        chk("out_fmt",      out_fmt,       h.fmt);
        chk("out_fmt32",    out_fmt32,     h.fmt);
        chk("out_illegal",  out_illegal,   h.ill);
        chk("out_illegal32", out_illegal32, h.ill);
        chk("out_tag",      out_tag,       h.tag);
        chk("out_tag32",    out_tag32,     h.tag);
    endtask

    // Called at a falling edge with inputs settled; returns whether a push happened.
    task automatic cycle(output bit accepted);
        bit push, pop;
        check_outputs();
        push = in_valid && mq.size() < 2;
        pop  = out_ready && mq.size() != 0;
        chk("no_push_when_full", in_valid && in_ready && mq.size() == 2, 1'b0);
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(model(in_instr, in_tag));
        end
        accepted = push && !flush;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] instr, input logic [63:0] tag);
        bit acc;
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        acc      = 1'b0;
        for (int n = 0; n < 10 && !acc; n++) cycle(acc);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    logic [31:0] directed [7] = '{32'hFFF00093, 32'h03F09093, 32'hFE21BC23, 32'hFE000EE3,
                                 32'h800002B7, 32'h001000EF, 32'h0000007F};
    logic [6:0]  ops [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f};

    initial begin
        bit          acc;
        logic [31:0] w;
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Spot checks of the hand-derived values before relying on the model.
        begin
            exp_t e;
            e = model(32'hFE21BC23, '0);
            chk("model_sd",  e.imm64, 64'hFFFFFFFFFFFFFFF8);
            e = model(32'hFE000EE3, '0);
            chk("model_beq", e.imm64, 64'hFFFFFFFFFFFFFFFC);
            e = model(32'h800002B7, '0);
            chk("model_lui32", e.imm32, 32'h80000000);
            e = model(32'h001000EF, '0);
            chk("model_jal", e.imm64, 64'h800);
        end

        out_ready = 1'b1;
        foreach (directed[k]) send(directed[k], 64'h1000 + 64'(k));
        repeat (2) cycle(acc);

        // Backpressure: the third push must wait until a slot frees.
        out_ready = 1'b0;
        send(32'hFFF00093, 64'h100);
        send(32'hFE21BC23, 64'h104);
        in_valid = 1'b1;
        in_instr = 32'h001000EF;
        in_tag   = 64'h108;
        cycle(acc);
        cycle(acc);
        chk("stall_blocks_push", acc, 1'b0);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 10 && !acc; n++) cycle(acc);
        chk("third_push_accepted", acc, 1'b1);
        in_valid = 1'b0;
        repeat (3) cycle(acc);

        // Flush with two queued and a new instruction presented.
        out_ready = 1'b0;
        send(32'h800002B7, 64'h200);
        send(32'hFE000EE3, 64'h204);
        in_valid = 1'b1;
        in_instr = 32'h03F09093;
        in_tag   = 64'h208;
        flush    = 1'b1;
        cycle(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle(acc);

        // Asynchronous reset between clock edges.
        send(32'hFFF00093, 64'h300);
        send(32'h0000007F, 64'h304);
        #2 rst_n = 1'b0;
        #1 mq.delete();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(acc);

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 500; n++) begin
            w        = $urandom();
            w[6:0]   = ops[$urandom_range(0, 8)];
            in_instr = w;
            in_tag   = {$urandom(), $urandom()};
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            cycle(acc);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle(acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
